// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - step codes and datapath constants shared by the MIPS sequencer
package mips_pkg;

    localparam int LARGURA_END   = 32;
    localparam int INCREMENTO_PC = 4;

    typedef enum logic [3:0] {
        PASSO_IDLE   = 4'd0,
        PASSO_PC     = 4'd1,
        PASSO_BUSCA  = 4'd2,
        PASSO_DECOD  = 4'd3,
        PASSO_EXEC   = 4'd4,
        PASSO_ESCR   = 4'd5,
        PASSO_PARADO = 4'd15
    } passo_t;

endpackage

// File: rtl/sequenciador_ciclos_if.sv
// rtl/sequenciador_ciclos_if.sv - fetch request/ready handshake with instruction memory
interface sequenciador_ciclos_if;
    import mips_pkg::*;

    logic                   busca;
    logic                   mem_pronto;
    logic [LARGURA_END-1:0] mem_dado;

    modport master (output busca, input mem_pronto, input mem_dado);
    modport slave  (input busca, output mem_pronto, output mem_dado);

endinterface

// File: rtl/sequenciador_ciclos_calc_endereco.sv
// rtl/sequenciador_ciclos_calc_endereco.sv - combinational next-address mux; jr path under SEQ_JR_EN
module calc_endereco #(
    parameter int LARGURA = 32,
    parameter int PASSO   = 4
) (
    input  logic [LARGURA-1:0] endAtual,
    input  logic [LARGURA-1:0] instrucao,
    input  logic [LARGURA-1:0] regA,
    input  logic               desvio,
    input  logic               salto,
    input  logic               jr,
    output logic [LARGURA-1:0] endCalc
);

    logic [LARGURA-1:0] end_seq;
    logic [LARGURA-1:0] end_mais4;
    logic [LARGURA-1:0] desloc;
    logic [LARGURA-1:0] end_desvio;
    logic [LARGURA-1:0] end_salto;
    logic               unused_bits;

    always_comb begin
        end_seq    = endAtual + LARGURA'(PASSO);
        end_mais4  = endAtual + LARGURA'(4);
        desloc     = {{(LARGURA-18){instrucao[15]}}, instrucao[15:0], 2'b00};
        end_desvio = end_mais4 + desloc;
        // jump keeps the region bits of PC+4 and replaces the rest with the word index
        end_salto  = {end_mais4[LARGURA-1 -: 4], instrucao[25:0], 2'b00};
    end

`ifdef SEQ_JR_EN
    always_comb begin
        if (jr)          endCalc = {regA[LARGURA-1:2], 2'b00};
        else if (salto)  endCalc = end_salto;
        else if (desvio) endCalc = end_desvio;
        else             endCalc = end_seq;
    end
    assign unused_bits = ^{instrucao[LARGURA-1:26], regA[1:0]};
`else
    always_comb begin
        if (salto)       endCalc = end_salto;
        else if (desvio) endCalc = end_desvio;
        else             endCalc = end_seq;
    end
    assign unused_bits = ^{instrucao[LARGURA-1:26], regA, jr};
`endif

endmodule

// File: rtl/sequenciador_ciclos.sv
// rtl/sequenciador_ciclos.sv - multi-cycle step sequencer and PC next-address register (SEQ_JR_EN enables jr)
module sequenciador_ciclos #(
    parameter int LARGURA  = mips_pkg::LARGURA_END,
    parameter int PASSO_PC = mips_pkg::INCREMENTO_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LARGURA-1:0]    endAtual,
    sequenciador_ciclos_if.master mem,
    input  logic                  desvio,
    input  logic                  salto,
    input  logic                  parar,
    input  logic [LARGURA-1:0]    regA,
    input  logic                  jr,
    output logic [3:0]            cont,
    output logic [LARGURA-1:0]    endProximo,
    output logic [LARGURA-1:0]    instrucao,
    output logic                  parado
);

    mips_pkg::passo_t   cont_q, cont_d;
    logic [LARGURA-1:0] end_proximo_q, end_proximo_d;
    logic [LARGURA-1:0] instrucao_q, instrucao_d;
    logic               busca_q, busca_d;
    logic               parado_q, parado_d;
    logic [LARGURA-1:0] end_calc;

    calc_endereco #(
        .LARGURA (LARGURA),
        .PASSO   (PASSO_PC)
    ) u_calc (
        .endAtual  (endAtual),
        .instrucao (instrucao_q),
        .regA      (regA),
        .desvio    (desvio),
        .salto     (salto),
        .jr        (jr),
        .endCalc   (end_calc)
    );

    always_comb begin
        cont_d        = cont_q;
        end_proximo_d = end_proximo_q;
        instrucao_d   = instrucao_q;
        busca_d       = busca_q;
        parado_d      = parado_q;
        case (cont_q)
            mips_pkg::PASSO_IDLE, mips_pkg::PASSO_PC: begin
                cont_d  = mips_pkg::PASSO_BUSCA;
                busca_d = 1'b1;
            end
            mips_pkg::PASSO_BUSCA: begin
                if (mem.mem_pronto) begin
                    cont_d      = mips_pkg::PASSO_DECOD;
                    busca_d     = 1'b0;
                    instrucao_d = mem.mem_dado;
                end
            end
            mips_pkg::PASSO_DECOD: cont_d = mips_pkg::PASSO_EXEC;
            mips_pkg::PASSO_EXEC: begin
                cont_d        = mips_pkg::PASSO_ESCR;
                end_proximo_d = end_calc;
            end
            mips_pkg::PASSO_ESCR: begin
                if (parar) begin
                    cont_d   = mips_pkg::PASSO_PARADO;
                    parado_d = 1'b1;
                end else begin
                    cont_d   = mips_pkg::PASSO_PC;
                end
            end
            mips_pkg::PASSO_PARADO: cont_d = mips_pkg::PASSO_PARADO;
            default: begin
                cont_d   = mips_pkg::PASSO_IDLE;
                busca_d  = 1'b0;
                parado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cont_q        <= mips_pkg::PASSO_IDLE;
            end_proximo_q <= '0;
            instrucao_q   <= '0;
            busca_q       <= 1'b0;
            parado_q      <= 1'b0;
        end else begin
            cont_q        <= cont_d;
            end_proximo_q <= end_proximo_d;
            instrucao_q   <= instrucao_d;
            busca_q       <= busca_d;
            parado_q      <= parado_d;
        end
    end

    assign cont       = cont_q;
    assign endProximo = end_proximo_q;
    assign instrucao  = instrucao_q;
    assign parado     = parado_q;
    assign mem.busca  = busca_q;

endmodule

// File: tb/tb_sequenciador_ciclos.sv
// tb/tb_sequenciador_ciclos.sv - scoreboard bench for sequenciador_ciclos (SEQ_JR_EN selects jr expectations)
module tb_sequenciador_ciclos;

`ifdef SEQ_JR_EN
    localparam bit JR_ATIVO = 1'b1;
`else
    localparam bit JR_ATIVO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] endAtual = '0;
    logic [31:0] regA = '0;
    logic        desvio = 1'b0;
    logic        salto = 1'b0;
    logic        parar = 1'b0;
    logic        jr = 1'b0;
    logic [3:0]  cont;
    logic [31:0] endProximo;
    logic [31:0] instrucao;
    logic        parado;

    int          n_testes = 0;
    int          n_falhas = 0;
    logic [31:0] fila_esp[$];

    sequenciador_ciclos_if mem_if();

    sequenciador_ciclos dut (
        .clk        (clk),
        .reset      (reset),
        .endAtual   (endAtual),
        .mem        (mem_if),
        .desvio     (desvio),
        .salto      (salto),
        .parar      (parar),
        .regA       (regA),
        .jr         (jr),
        .cont       (cont),
        .endProximo (endProximo),
        .instrucao  (instrucao),
        .parado     (parado)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_testes++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obtido, esperado);
        end
    endtask

    function automatic logic [31:0] modelo(input logic [31:0] pc, input logic [31:0] palavra,
                                           input logic [31:0] ra, input logic d, input logic s,
                                           input logic j);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (JR_ATIVO && j) return {ra[31:2], 2'b00};
        if (s) return {p4[31:28], palavra[25:0], 2'b00};
        if (d) return p4 + {{14{palavra[15]}}, palavra[15:0], 2'b00};
        return p4;
    endfunction

    task automatic aguarda_passo(input logic [3:0] v, input string tag);
        for (int i = 0; i < 30 && cont != v; i++) @(negedge clk);
        verifica(tag, cont, v);
    endtask

    task automatic confere_fila(input string tag);
        logic [31:0] e;
        verifica("fila_tam", fila_esp.size(), 32'd1);
        if (fila_esp.size() > 0) begin
            e = fila_esp.pop_front();
            verifica(tag, endProximo, e);
        end
    endtask

    task automatic aplica_reset();
        reset = 1'b1;
        @(negedge clk);
        verifica("rst_cont", cont, 32'd0);
        verifica("rst_busca", mem_if.busca, 32'd0);
        verifica("rst_endProximo", endProximo, 32'd0);
        verifica("rst_instrucao", instrucao, 32'd0);
        verifica("rst_parado", parado, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        verifica("primeira_busca_cont", cont, 32'd2);
        verifica("primeira_busca", mem_if.busca, 32'd1);
    endtask

    task automatic executa_instr(input logic [31:0] pc, input logic [31:0] palavra, input int espera,
                                 input logic d, input logic s, input logic j, input logic [31:0] ra,
                                 input logic para, input logic [31:0] esperado);
        logic [31:0] instr_ant;
        endAtual = pc;
        regA     = ra;
        parar    = 1'b0;
        desvio   = 1'b0;
        salto    = 1'b0;
        jr       = 1'b0;
        mem_if.mem_pronto = (espera == 0);
        mem_if.mem_dado   = (espera == 0) ? palavra : 32'hDEADBEEF;
        fila_esp.push_back(esperado);
        aguarda_passo(4'd2, "entra_busca");
        instr_ant = instrucao;
        for (int k = 0; k <= espera; k++) begin
            mem_if.mem_pronto = (k == espera);
            mem_if.mem_dado   = (k == espera) ? palavra : 32'hDEADBEEF;
            verifica("busca_alto", mem_if.busca, 32'd1);
            verifica("cont_busca", cont, 32'd2);
            if (k > 0) verifica("instr_retida", instrucao, instr_ant);
            @(negedge clk);
        end
        mem_if.mem_pronto = 1'b1;
        mem_if.mem_dado   = ~palavra;
        desvio = 1'b1; salto = 1'b1; jr = 1'b1; parar = 1'b1;
        verifica("cont_decod", cont, 32'd3);
        verifica("busca_baixo", mem_if.busca, 32'd0);
        verifica("instrucao", instrucao, palavra);
        @(negedge clk);
        desvio = d; salto = s; jr = j;
        verifica("cont_exec", cont, 32'd4);
        @(negedge clk);
        desvio = 1'b1; salto = 1'b1; jr = 1'b1; parar = para;
        verifica("cont_escr", cont, 32'd5);
        @(negedge clk);
        desvio = 1'b0; salto = 1'b0; jr = 1'b0;
        if (para) begin
            verifica("cont_parado", cont, 32'd15);
            verifica("parado_alto", parado, 32'd1);
            confere_fila("endProximo_parado");
            parar = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                verifica("parado_cont", cont, 32'd15);
                verifica("parado_busca", mem_if.busca, 32'd0);
                verifica("parado_mantido", parado, 32'd1);
            end
        end else begin
            verifica("cont_pc", cont, 32'd1);
            verifica("parado_baixo", parado, 32'd0);
            confere_fila("endProximo");
        end
    endtask

    initial begin
        logic [31:0] pc, palavra;
        logic        d, s;
        int          esp;
        mem_if.mem_pronto = 1'b1;
        mem_if.mem_dado   = '0;
        @(negedge clk);
        aplica_reset();

        executa_instr(32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0004);
        executa_instr(32'h0000_0100, 32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_00FC);
        executa_instr(32'h4000_0000, 32'h0800_0010, 0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h4000_0040);
        executa_instr(32'h0000_1000, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_1004);
        executa_instr(32'hFFFF_FFFC, 32'h0000_0001, 1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000);

        for (int r = 0; r < 4; r++) begin
            pc      = $urandom & 32'hFFFF_FFFC;
            palavra = $urandom;
            d       = 1'($urandom_range(0, 1));
            s       = 1'($urandom_range(0, 1));
            esp     = $urandom_range(0, 2);
            executa_instr(pc, palavra, esp, d, s, 1'b0, 32'h0, 1'b0, modelo(pc, palavra, 32'h0, d, s, 1'b0));
        end

        // reset while a fetch is outstanding
        mem_if.mem_pronto = 1'b0;
        @(negedge clk);
        verifica("meio_busca_cont", cont, 32'd2);
        verifica("meio_busca_busca", mem_if.busca, 32'd1);
        aplica_reset();

        executa_instr(32'h0000_0100, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 32'h0040_0023, 1'b0,
                      JR_ATIVO ? 32'h0040_0020 : 32'h0000_0104);
        executa_instr(32'h0000_2000, 32'h0000_0003, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2004);
        aplica_reset();

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
